axi_lite_reg_file_da: RTL and testbench
=======================================

Name: axi_lite_reg_file_da

Overview:
- AXI4-Lite slave wrapping a flat register file of NUM_REGISTERS words.
- Software reads/writes registers over AXI. Hardware sees every register in parallel and can overwrite any register directly.
- Each AXI write to a register raises a one-cycle trigger for that register, so control logic can react to software commands.
- Sits between the system AXI-Lite control interconnect and a peripheral's control/status logic.

Parameters:
- REGISTER_WIDTH, 32, register and AXI data width; must be 32 or 64.
- NUM_REGISTERS, 8, number of registers; 1..256.
- ADDR_WIDTH, 12, AXI address width in bits.

Ports:
- clk  in  1  single clock for all logic
- rst  in  1  synchronous reset, active-high
- s_axi_awaddr  in  ADDR_WIDTH  write address (byte)
- s_axi_awprot  in  3  ignored
- s_axi_awvalid  in  1  write address valid
- s_axi_awready  out  1  write address ready
- s_axi_wdata  in  REGISTER_WIDTH  write data
- s_axi_wstrb  in  REGISTER_WIDTH/8  byte strobes
- s_axi_wvalid  in  1  write data valid
- s_axi_wready  out  1  write data ready
- s_axi_bresp  out  2  write response
- s_axi_bvalid  out  1  write response valid
- s_axi_bready  in  1  write response ready
- s_axi_araddr  in  ADDR_WIDTH  read address (byte)
- s_axi_arprot  in  3  ignored
- s_axi_arvalid  in  1  read address valid
- s_axi_arready  out  1  read address ready
- s_axi_rdata  out  REGISTER_WIDTH  read data
- s_axi_rresp  out  2  read response
- s_axi_rvalid  out  1  read data valid
- s_axi_rready  in  1  read data ready
- o_reg_data  out  NUM_REGISTERS*REGISTER_WIDTH  all register contents; register i at bits [i*W +: W]
- i_hw_wr_en  in  NUM_REGISTERS  per-register hardware write enable
- i_hw_wr_data  in  NUM_REGISTERS*REGISTER_WIDTH  hardware write data, same packing as o_reg_data
- o_axi_ctrl_trigger  out  NUM_REGISTERS  one-cycle pulse per register written by AXI

Behaviour:
- Reset (rst=1 at clk edge):
  - All registers 0.
  - All ready/valid outputs 0; bresp/rresp 0; rdata 0; o_axi_ctrl_trigger 0.
  - Any in-flight transaction is dropped. The master must not expect B or R completion across a reset.
- Addressing:
  - Register index = addr >> log2(REGISTER_WIDTH/8); low byte-offset bits ignored.
  - Index >= NUM_REGISTERS is out of range.
- Write channel:
  - Write FSM states IDLE and RESP.
  - In IDLE, awready and wready are asserted together, combinationally, only when awvalid && wvalid. Both handshakes complete in the same cycle.
  - Registered outputs update at the handshake edge:
    - In range: register byte k takes wdata byte k where wstrb[k]=1; o_axi_ctrl_trigger[idx] is 1 for exactly the next cycle; bresp=OKAY (00).
    - Out of range: no register change, no trigger, bresp=SLVERR (10).
  - bvalid rises on the cycle after the handshake; the FSM moves to RESP.
  - In RESP, bvalid is held, AW/W are not accepted, and bresp is stable. The FSM returns to IDLE on bvalid && bready.
  - Maximum throughput: one write per 2 cycles.
- Read channel:
  - Read FSM states IDLE and DATA.
  - In IDLE, arready=1. On arvalid, the FSM captures rdata: register contents in range with rresp=OKAY, else 0 with rresp=SLVERR.
  - rvalid rises on the next cycle. In DATA, arready=0 and rdata/rresp are held until rvalid && rready.
  - Read and write channels are independent and may be active simultaneously.
- Hardware writes:
  - i_hw_wr_en[i]=1 loads register i with its i_hw_wr_data slice at the next edge.
  - Hardware writes never produce triggers.
- Simultaneous AXI write and hardware write to the same register in the same cycle:
  - AXI wins for the bytes enabled by wstrb.
  - Hardware data is stored in the non-strobed bytes.
  - The trigger still fires.
- o_reg_data is a direct registered view of the registers; an update is visible the cycle after the write edge.
- Read-after-write: a read accepted in the same cycle as a write handshake to the same register returns the old value.

Test Plan:
- Reset: hold rst=1 for 6 cycles with AXI idle -> all o_reg_data 0, bvalid=rvalid=0, triggers 0.
- AXI write then read: write addr 0x04 data 0xDEADBEEF wstrb 0xF -> bresp OKAY one cycle after handshake; o_axi_ctrl_trigger=0b0010 for exactly one cycle; o_reg_data reg1=0xDEADBEEF; read 0x04 returns 0xDEADBEEF with rresp OKAY.
- Byte strobes: reg2=0x11223344, then write 0xAABBCCDD with wstrb 0b0101 -> reg2=0x11BB33DD.
- Hardware write: pulse i_hw_wr_en[3] with 0x0000CAFE -> reg3=0x0000CAFE; AXI read 0x0C returns it; no trigger.
- Out of range: write and read at addr 0x20 (NUM_REGISTERS=8) -> bresp SLVERR, rresp SLVERR, rdata 0, no register change, no trigger.
- Backpressure and collision:
  - Hold bready=0 for 5 cycles -> bvalid and bresp stable, awready=0 throughout.
  - Same-cycle AXI write (wstrb 0x3, data 0x0000FFFF) and hardware write (0x12345678) to reg0 -> reg0=0x1234FFFF; trigger[0] pulses.

Source files
------------

// File: rtl/axi_lite_reg_file_da.sv
// AXI4-Lite slave over a flat register file with a parallel hardware view,
// per-register hardware overwrite and a one-cycle trigger on every AXI write.
module axi_lite_reg_file_da #(
    parameter int REGISTER_WIDTH = 32,
    parameter int NUM_REGISTERS  = 8,
    parameter int ADDR_WIDTH     = 12
) (
    input  logic                                      clk,
    input  logic                                      rst,

    input  logic [ADDR_WIDTH-1:0]                     s_axi_awaddr,
    input  logic [2:0]                                s_axi_awprot,
    input  logic                                      s_axi_awvalid,
    output logic                                      s_axi_awready,
    input  logic [REGISTER_WIDTH-1:0]                 s_axi_wdata,
    input  logic [REGISTER_WIDTH/8-1:0]               s_axi_wstrb,
    input  logic                                      s_axi_wvalid,
    output logic                                      s_axi_wready,
    output logic [1:0]                                s_axi_bresp,
    output logic                                      s_axi_bvalid,
    input  logic                                      s_axi_bready,

    input  logic [ADDR_WIDTH-1:0]                     s_axi_araddr,
    input  logic [2:0]                                s_axi_arprot,
    input  logic                                      s_axi_arvalid,
    output logic                                      s_axi_arready,
    output logic [REGISTER_WIDTH-1:0]                 s_axi_rdata,
    output logic [1:0]                                s_axi_rresp,
    output logic                                      s_axi_rvalid,
    input  logic                                      s_axi_rready,

    output logic [NUM_REGISTERS*REGISTER_WIDTH-1:0]   o_reg_data,
    input  logic [NUM_REGISTERS-1:0]                  i_hw_wr_en,
    input  logic [NUM_REGISTERS*REGISTER_WIDTH-1:0]   i_hw_wr_data,
    output logic [NUM_REGISTERS-1:0]                  o_axi_ctrl_trigger
);

    localparam int STRB_W   = REGISTER_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(STRB_W);
    localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic { WR_IDLE, WR_RESP } wr_state_t;
    typedef enum logic { RD_IDLE, RD_DATA } rd_state_t;

    wr_state_t wr_state, wr_state_next;
    rd_state_t rd_state, rd_state_next;

    logic [IDX_W-1:0]          wr_idx;
    logic [IDX_W-1:0]          rd_idx;
    logic                      wr_hs;
    logic                      rd_hs;
    logic [NUM_REGISTERS-1:0]  wr_match;
    logic [REGISTER_WIDTH-1:0] rd_value;
    logic                      rd_hit;
    logic [REGISTER_WIDTH-1:0] regs [NUM_REGISTERS];

    assign wr_idx = s_axi_awaddr[ADDR_WIDTH-1:ADDR_LSB];
    assign rd_idx = s_axi_araddr[ADDR_WIDTH-1:ADDR_LSB];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        wr_state_next = wr_state;
        wr_hs         = 1'b0;
        case (wr_state)
            WR_IDLE: begin
                if (!rst && s_axi_awvalid && s_axi_wvalid) begin
                    wr_hs         = 1'b1;
                    wr_state_next = WR_RESP;
                end
            end
            WR_RESP: begin
                if (s_axi_bready) begin
                    wr_state_next = WR_IDLE;
                end
            end
            default: wr_state_next = WR_IDLE;
        endcase
    end

    always_comb begin
        rd_state_next = rd_state;
        rd_hs         = 1'b0;
        case (rd_state)
            RD_IDLE: begin
                if (!rst && s_axi_arvalid) begin
                    rd_hs         = 1'b1;
                    rd_state_next = RD_DATA;
                end
            end
            RD_DATA: begin
                if (s_axi_rready) begin
                    rd_state_next = RD_IDLE;
                end
            end
            default: rd_state_next = RD_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state <= WR_IDLE;
            rd_state <= RD_IDLE;
        end else begin
            wr_state <= wr_state_next;
            rd_state <= rd_state_next;
        end
    end

    // AW and W are accepted only as a pair, so both readies are the handshake itself.
    assign s_axi_awready = wr_hs;
    assign s_axi_wready  = wr_hs;
    assign s_axi_bvalid  = (wr_state == WR_RESP);
    assign s_axi_arready = !rst && (rd_state == RD_IDLE);
    assign s_axi_rvalid  = (rd_state == RD_DATA);

    always_comb begin
        wr_match = '0;
        rd_value = '0;
        rd_hit   = 1'b0;
        for (int i = 0; i < NUM_REGISTERS; i++) begin
            wr_match[i] = wr_hs && (wr_idx == IDX_W'(i));
            if (rd_idx == IDX_W'(i)) begin
                rd_value = regs[i];
                rd_hit   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_axi_bresp        <= RESP_OKAY;
            s_axi_rdata        <= '0;
            s_axi_rresp        <= RESP_OKAY;
            o_axi_ctrl_trigger <= '0;
        end else begin
            o_axi_ctrl_trigger <= wr_match;
            if (wr_hs) begin
                s_axi_bresp <= (|wr_match) ? RESP_OKAY : RESP_SLVERR;
            end
            if (rd_hs) begin
                s_axi_rdata <= rd_value;
                s_axi_rresp <= rd_hit ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    // NOTE: this array is a bank of flops, not a RAM, so resetting every word is intended.
    // Strobed AXI bytes take priority; hardware data fills the remaining bytes.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGISTERS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGISTERS; i++) begin
                for (int k = 0; k < STRB_W; k++) begin
                    if (wr_match[i] && s_axi_wstrb[k]) begin
                        regs[i][k*8 +: 8] <= s_axi_wdata[k*8 +: 8];
                    end else if (i_hw_wr_en[i]) begin
                        regs[i][k*8 +: 8] <= i_hw_wr_data[i*REGISTER_WIDTH + k*8 +: 8];
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REGISTERS; g++) begin : g_view
        assign o_reg_data[g*REGISTER_WIDTH +: REGISTER_WIDTH] = regs[g];
    end

    logic unused_ok;
    assign unused_ok = ^{s_axi_awprot, s_axi_arprot,
                         s_axi_awaddr[ADDR_LSB-1:0], s_axi_araddr[ADDR_LSB-1:0]};

endmodule

// File: tb/tb_axi_lite_reg_file_da.sv
// Bench for axi_lite_reg_file_da: directed scenarios plus randomized traffic,
// all compared every cycle against a transaction-level model of the register file.
module tb_axi_lite_reg_file_da;

    localparam int W      = 32;
    localparam int N      = 8;
    localparam int AW     = 12;
    localparam int SW     = W / 8;
    localparam int BUDGET = 50;

    logic            clk = 1'b0;
    logic            rst;
    logic [AW-1:0]   s_axi_awaddr;
    logic [2:0]      s_axi_awprot;
    logic            s_axi_awvalid;
    logic            s_axi_awready;
    logic [W-1:0]    s_axi_wdata;
    logic [SW-1:0]   s_axi_wstrb;
    logic            s_axi_wvalid;
    logic            s_axi_wready;
    logic [1:0]      s_axi_bresp;
    logic            s_axi_bvalid;
    logic            s_axi_bready;
    logic [AW-1:0]   s_axi_araddr;
    logic [2:0]      s_axi_arprot;
    logic            s_axi_arvalid;
    logic            s_axi_arready;
    logic [W-1:0]    s_axi_rdata;
    logic [1:0]      s_axi_rresp;
    logic            s_axi_rvalid;
    logic            s_axi_rready;
    logic [N*W-1:0]  o_reg_data;
    logic [N-1:0]    i_hw_wr_en;
    logic [N*W-1:0]  i_hw_wr_data;
    logic [N-1:0]    o_axi_ctrl_trigger;

    always #5 clk = ~clk;

    axi_lite_reg_file_da #(
        .REGISTER_WIDTH (W),
        .NUM_REGISTERS  (N),
        .ADDR_WIDTH     (AW)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .s_axi_awaddr       (s_axi_awaddr),
        .s_axi_awprot       (s_axi_awprot),
        .s_axi_awvalid      (s_axi_awvalid),
        .s_axi_awready      (s_axi_awready),
        .s_axi_wdata        (s_axi_wdata),
        .s_axi_wstrb        (s_axi_wstrb),
        .s_axi_wvalid       (s_axi_wvalid),
        .s_axi_wready       (s_axi_wready),
        .s_axi_bresp        (s_axi_bresp),
        .s_axi_bvalid       (s_axi_bvalid),
        .s_axi_bready       (s_axi_bready),
        .s_axi_araddr       (s_axi_araddr),
        .s_axi_arprot       (s_axi_arprot),
        .s_axi_arvalid      (s_axi_arvalid),
        .s_axi_arready      (s_axi_arready),
        .s_axi_rdata        (s_axi_rdata),
        .s_axi_rresp        (s_axi_rresp),
        .s_axi_rvalid       (s_axi_rvalid),
        .s_axi_rready       (s_axi_rready),
        .o_reg_data         (o_reg_data),
        .i_hw_wr_en         (i_hw_wr_en),
        .i_hw_wr_data       (i_hw_wr_data),
        .o_axi_ctrl_trigger (o_axi_ctrl_trigger)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: a word array plus "response owed" flags, advanced per clock edge.
    logic [W-1:0] m_regs [N];
    logic [W-1:0] m_nxt  [N];
    bit           m_valid = 1'b0;
    bit           m_after_rst;
    bit           m_b_pend;
    bit           m_r_pend;
    logic [1:0]   m_bresp;
    logic [1:0]   m_rresp;
    logic [W-1:0] m_rdata;
    logic [N-1:0] m_trig;
    bit           w_acc;
    bit           r_acc;
    int           widx;
    int           ridx;

    always @(posedge clk) begin
        m_after_rst = rst;
        if (rst) begin
            m_valid  = 1'b1;
            for (int i = 0; i < N; i++) m_regs[i] = '0;
            m_b_pend = 1'b0;
            m_r_pend = 1'b0;
            m_bresp  = 2'b00;
            m_rresp  = 2'b00;
            m_rdata  = '0;
            m_trig   = '0;
        end else if (m_valid) begin
            w_acc  = !m_b_pend && s_axi_awvalid && s_axi_wvalid;
            r_acc  = !m_r_pend && s_axi_arvalid;
            m_trig = '0;
            for (int i = 0; i < N; i++)
                m_nxt[i] = i_hw_wr_en[i] ? i_hw_wr_data[i*W +: W] : m_regs[i];
            if (w_acc) begin
                widx = int'(s_axi_awaddr) / SW;
                if (widx < N) begin
                    for (int k = 0; k < SW; k++)
                        if (s_axi_wstrb[k]) m_nxt[widx][8*k +: 8] = s_axi_wdata[8*k +: 8];
                    m_trig[widx] = 1'b1;
                    m_bresp      = 2'b00;
                end else begin
                    m_bresp = 2'b10;
                end
                m_b_pend = 1'b1;
            end else if (m_b_pend && s_axi_bready) begin
                m_b_pend = 1'b0;
            end
            if (r_acc) begin
                ridx = int'(s_axi_araddr) / SW;
                if (ridx < N) begin
                    m_rdata = m_regs[ridx];
                    m_rresp = 2'b00;
                end else begin
                    m_rdata = '0;
                    m_rresp = 2'b10;
                end
                m_r_pend = 1'b1;
            end else if (m_r_pend && s_axi_rready) begin
                m_r_pend = 1'b0;
            end
            for (int i = 0; i < N; i++) m_regs[i] = m_nxt[i];
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("awready", 64'(s_axi_awready), 64'(!rst && !m_b_pend && s_axi_awvalid && s_axi_wvalid));
            check("wready",  64'(s_axi_wready),  64'(!rst && !m_b_pend && s_axi_awvalid && s_axi_wvalid));
            check("bvalid",  64'(s_axi_bvalid),  64'(m_b_pend));
            if (m_b_pend || m_after_rst) check("bresp", 64'(s_axi_bresp), 64'(m_bresp));
            check("arready", 64'(s_axi_arready), 64'(!rst && !m_r_pend));
            check("rvalid",  64'(s_axi_rvalid),  64'(m_r_pend));
            if (m_r_pend || m_after_rst) begin
                check("rdata", 64'(s_axi_rdata), 64'(m_rdata));
                check("rresp", 64'(s_axi_rresp), 64'(m_rresp));
            end
            check("trigger", 64'(o_axi_ctrl_trigger), 64'(m_trig));
            for (int i = 0; i < N; i++)
                check($sformatf("reg%0d", i), 64'(o_reg_data[i*W +: W]), 64'(m_regs[i]));
        end
    end

    task automatic sync();
        @(posedge clk);
        #2;
    endtask

    task automatic axi_write(input logic [AW-1:0] a, input logic [W-1:0] d, input logic [SW-1:0] s);
        int n;
        n = 0;
        s_axi_awaddr  = a;
        s_axi_wdata   = d;
        s_axi_wstrb   = s;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        #1;
        while (!s_axi_awready && n < BUDGET) begin
            @(posedge clk);
            #3;
            n++;
        end
        check("aw_wait_budget", 64'(n >= BUDGET), 64'(0));
        @(posedge clk);
        #2;
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
    endtask

    task automatic axi_read(input logic [AW-1:0] a, output logic [W-1:0] d, output logic [1:0] r);
        int n;
        n = 0;
        s_axi_araddr  = a;
        s_axi_arvalid = 1'b1;
        #1;
        while (!s_axi_arready && n < BUDGET) begin
            @(posedge clk);
            #3;
            n++;
        end
        check("ar_wait_budget", 64'(n >= BUDGET), 64'(0));
        @(posedge clk);
        #2;
        s_axi_arvalid = 1'b0;
        @(negedge clk);
        d = s_axi_rdata;
        r = s_axi_rresp;
        @(posedge clk);
        #2;
    endtask

    logic [W-1:0] rd;
    logic [1:0]   rr;

    initial begin
        rst           = 1'b1;
        s_axi_awaddr  = '0;
        s_axi_awprot  = '0;
        s_axi_awvalid = 1'b0;
        s_axi_wdata   = '0;
        s_axi_wstrb   = '0;
        s_axi_wvalid  = 1'b0;
        s_axi_bready  = 1'b1;
        s_axi_araddr  = '0;
        s_axi_arprot  = '0;
        s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b1;
        i_hw_wr_en    = '0;
        i_hw_wr_data  = '0;

        repeat (6) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < N; i++)
            check($sformatf("rst_reg%0d", i), 64'(o_reg_data[i*W +: W]), 64'(0));
        check("rst_bvalid", 64'(s_axi_bvalid), 64'(0));
        check("rst_rvalid", 64'(s_axi_rvalid), 64'(0));
        check("rst_trigger", 64'(o_axi_ctrl_trigger), 64'(0));
        sync();
        rst = 1'b0;

        // Write then read back register 1.
        axi_write(12'h004, 32'hDEADBEEF, 4'hF);
        #1;
        check("wr1_trigger", 64'(o_axi_ctrl_trigger), 64'(8'b0000_0010));
        check("wr1_bvalid", 64'(s_axi_bvalid), 64'(1));
        check("wr1_bresp", 64'(s_axi_bresp), 64'(2'b00));
        check("wr1_reg1", 64'(o_reg_data[1*W +: W]), 64'(32'hDEADBEEF));
        check("model_reg1", 64'(m_regs[1]), 64'(32'hDEADBEEF));
        sync();
        #1;
        check("wr1_trigger_drop", 64'(o_axi_ctrl_trigger), 64'(0));
        sync();
        axi_read(12'h004, rd, rr);
        check("rd1_data", 64'(rd), 64'(32'hDEADBEEF));
        check("rd1_resp", 64'(rr), 64'(2'b00));

        // Byte strobes on register 2.
        axi_write(12'h008, 32'h11223344, 4'hF);
        axi_write(12'h008, 32'hAABBCCDD, 4'b0101);
        #1;
        check("strb_reg2", 64'(o_reg_data[2*W +: W]), 64'(32'h11BB33DD));
        check("model_reg2", 64'(m_regs[2]), 64'(32'h11BB33DD));
        sync();

        // Hardware write to register 3.
        i_hw_wr_en             = 8'b0000_1000;
        i_hw_wr_data[3*W +: W] = 32'h0000CAFE;
        sync();
        i_hw_wr_en = '0;
        #1;
        check("hw_reg3", 64'(o_reg_data[3*W +: W]), 64'(32'h0000CAFE));
        check("hw_no_trigger", 64'(o_axi_ctrl_trigger), 64'(0));
        sync();
        axi_read(12'h00C, rd, rr);
        check("rd3_data", 64'(rd), 64'(32'h0000CAFE));
        check("rd3_resp", 64'(rr), 64'(2'b00));

        // Out-of-range access.
        axi_write(12'h020, 32'h55AA55AA, 4'hF);
        #1;
        check("oor_bresp", 64'(s_axi_bresp), 64'(2'b10));
        check("oor_trigger", 64'(o_axi_ctrl_trigger), 64'(0));
        check("oor_reg1", 64'(o_reg_data[1*W +: W]), 64'(32'hDEADBEEF));
        sync();
        axi_read(12'h020, rd, rr);
        check("oor_rdata", 64'(rd), 64'(0));
        check("oor_rresp", 64'(rr), 64'(2'b10));

        // Write-response backpressure with a second write waiting.
        s_axi_bready = 1'b0;
        axi_write(12'h010, 32'h0BADF00D, 4'hF);
        s_axi_awaddr  = 12'h014;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("bp_bvalid", 64'(s_axi_bvalid), 64'(1));
            check("bp_bresp", 64'(s_axi_bresp), 64'(2'b00));
            check("bp_awready", 64'(s_axi_awready), 64'(0));
            sync();
        end
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        s_axi_bready  = 1'b1;
        sync();

        // AXI and hardware write to register 0 in the same cycle.
        s_axi_awaddr           = 12'h000;
        s_axi_wdata            = 32'h0000FFFF;
        s_axi_wstrb            = 4'h3;
        s_axi_awvalid          = 1'b1;
        s_axi_wvalid           = 1'b1;
        i_hw_wr_en             = 8'b0000_0001;
        i_hw_wr_data[0*W +: W] = 32'h12345678;
        #1;
        check("coll_awready", 64'(s_axi_awready), 64'(1));
        sync();
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        i_hw_wr_en    = '0;
        #1;
        check("coll_reg0", 64'(o_reg_data[0*W +: W]), 64'(32'h1234FFFF));
        check("coll_trigger", 64'(o_axi_ctrl_trigger), 64'(8'b0000_0001));
        sync();

        // Randomized traffic, including out-of-range addresses and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            rst           = ($urandom_range(0, 299) == 0);
            s_axi_awaddr  = AW'($urandom_range(0, 'h27));
            s_axi_wdata   = $urandom;
            s_axi_wstrb   = SW'($urandom);
            s_axi_awvalid = $urandom_range(0, 1) == 1;
            s_axi_wvalid  = $urandom_range(0, 2) != 0;
            s_axi_bready  = $urandom_range(0, 2) != 0;
            s_axi_araddr  = AW'($urandom_range(0, 'h27));
            s_axi_arvalid = $urandom_range(0, 1) == 1;
            s_axi_rready  = $urandom_range(0, 2) != 0;
            for (int i = 0; i < N; i++) begin
                i_hw_wr_en[i]          = ($urandom_range(0, 7) == 0);
                i_hw_wr_data[i*W +: W] = $urandom;
            end
            sync();
        end

        rst           = 1'b0;
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        s_axi_arvalid = 1'b0;
        s_axi_bready  = 1'b1;
        s_axi_rready  = 1'b1;
        i_hw_wr_en    = '0;
        repeat (4) sync();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
